// File: rtl/uart_pkg.sv
// Shared UART definitions: state encodings, data width and parity helper.
package uart_pkg;

  localparam int unsigned DATA_W = 8;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_e;

  // Even parity is the XOR of the data bits; odd parity is its inverse.
  function automatic logic parity_bit(input logic [DATA_W-1:0] d, input logic odd);
    return (^d) ^ odd;
  endfunction

endpackage

// File: rtl/tx_mod_baud_gen.sv
// Bit-period counter: strikes bit_end on the last cycle of each bit period.
// The sync clear holds the count at zero so a frame's first bit is full length.
module baud_gen #(
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic bclk,
  input  logic rst,
  input  logic clr,
  output logic bit_end
);

  localparam int unsigned CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt;

  // Count 0..CLKS_PER_BIT-1, wrap at each bit boundary, hold at zero while cleared.
  always_ff @(posedge bclk or posedge rst) begin
    if (rst)
      cnt <= '0;
    else if (clr || cnt == LAST)
      cnt <= '0;
    else
      cnt <= cnt + CW'(1);
  end

  assign bit_end = (cnt == LAST) && !clr;

endmodule

// File: rtl/tx_mod.sv
// UART transmitter: start bit, 8 data bits LSB first, optional parity, 1 or 2 stop bits.
module tx_mod
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned PARITY_EN    = 0,
  parameter int unsigned PARITY_ODD   = 0,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic       bclk,
  input  logic       rst,
  input  logic [7:0] din,
  input  logic       wr,
  output logic       tx,
  output logic       tx_rdy,
  output logic       done
);

  uart_state_e       state;
  logic [DATA_W-1:0] shreg;
  logic [2:0]        bit_cnt;
  logic              stop_cnt;
  logic              par;
  logic              bit_end;

  baud_gen #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
    .bclk    (bclk),
    .rst     (rst),
    .clr     (state == IDLE),
    .bit_end (bit_end)
  );

  // Frame sequencer; tx, tx_rdy and done are all registered here.
  // tx is loaded with the next bit value on the boundary edge, so shreg[1] is
  // presented while shreg shifts.
  always_ff @(posedge bclk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      shreg    <= '0;
      bit_cnt  <= '0;
      stop_cnt <= 1'b0;
      par      <= 1'b0;
      tx       <= 1'b1;
      tx_rdy   <= 1'b1;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          tx     <= 1'b1;
          tx_rdy <= 1'b1;
          if (wr) begin
            shreg    <= din;
            par      <= parity_bit(din, PARITY_ODD != 0);
            bit_cnt  <= '0;
            stop_cnt <= 1'b0;
            tx       <= 1'b0;
            tx_rdy   <= 1'b0;
            state    <= START;
          end
        end
        START: begin
          if (bit_end) begin
            tx    <= shreg[0];
            state <= DATA;
          end
        end
        DATA: begin
          if (bit_end) begin
            if (bit_cnt == 3'd7) begin
              if (PARITY_EN != 0) begin
                tx    <= par;
                state <= PARITY;
              end else begin
                tx    <= 1'b1;
                state <= STOP;
              end
            end else begin
              bit_cnt <= bit_cnt + 3'd1;
              shreg   <= shreg >> 1;
              tx      <= shreg[1];
            end
          end
        end
        PARITY: begin
          if (bit_end) begin
            tx    <= 1'b1;
            state <= STOP;
          end
        end
        STOP: begin
          if (bit_end) begin
            if (stop_cnt || STOP_BITS == 1) begin
              done   <= 1'b1;
              tx_rdy <= 1'b1;
              state  <= IDLE;
            end else begin
              stop_cnt <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/tx_mod.md
Name: tx_mod

Overview:
UART transmitter, the transmit-side counterpart of the team's UART receiver in UART_controller.
- Serialises a parallel byte onto a single line: start bit, 8 data bits LSB first (d0 first), optional parity bit, 1 or 2 stop bits.
- Bit timing is generated internally from the system clock.
- Accepts bytes through a ready/write handshake from the controller core.

Parameters:
CLKS_PER_BIT, 16, bclk cycles per serial bit period; legal range >= 2.
PARITY_EN, 0, 1 inserts a parity bit after d7.
PARITY_ODD, 0, 0 = even parity, 1 = odd parity; ignored when PARITY_EN = 0.
STOP_BITS, 1, number of stop bits; legal values 1 or 2.

Ports:
bclk  input  1  system clock; all logic on the rising edge.
rst  input  1  reset, asynchronous, active-high.
din  input  8  byte to send, [7:0], d0 transmitted first.
wr  input  1  write strobe; byte accepted when wr & tx_rdy.
tx  output  1  serial line; idles high.
tx_rdy  output  1  high when a new byte can be accepted.
done  output  1  one-cycle pulse when a frame's last stop bit completes.

Behaviour:
- Reset (async, any time, including mid-frame):
  - tx = 1, tx_rdy = 1, done = 0.
  - State = IDLE; bit counter, baud counter and shift register cleared.
  - No partial frame resumes after reset release.
- Registered outputs: tx, tx_rdy and done are driven from flops, so tx has no glitches.
- States: IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - tx = 1, tx_rdy = 1.
  - On wr = 1: latch din into the shift register, compute the parity bit from din (even: XOR of bits; odd: inverted XOR), clear the baud counter, go to START.
  - tx_rdy = 0 from the next cycle.
- Latency: tx falls on the first cycle after the accepting edge.
- START: tx = 0 for CLKS_PER_BIT cycles, then DATA.
- DATA:
  - tx = shreg[0] for CLKS_PER_BIT cycles per bit; shift right at each bit boundary.
  - 3-bit counter 0..7; after bit 7 go to PARITY if PARITY_EN = 1, else STOP.
- PARITY: tx = parity bit for CLKS_PER_BIT cycles, then STOP.
- STOP:
  - tx = 1 for STOP_BITS*CLKS_PER_BIT cycles.
  - On the final cycle: go to IDLE; done = 1 and tx_rdy = 1 on the following cycle.
- Baud counter:
  - Width clog2(CLKS_PER_BIT), counts 0..CLKS_PER_BIT-1, wraps to 0 at each bit boundary.
  - Resets to 0 on frame start only, not free-running, so the first bit is exactly CLKS_PER_BIT long.
- Frame length: CLKS_PER_BIT*(10 + PARITY_EN + STOP_BITS - 1) cycles from the first tx-low cycle to the first IDLE cycle.
- Back-to-back: wr may be held high continuously; a new byte is accepted in the first IDLE cycle (the cycle done = 1). The idle gap between frames is 1 cycle.
- wr while tx_rdy = 0: ignored. din need not be held after acceptance.
- Simultaneous wr and rst: reset wins; the byte is dropped.

Decomposition:
- Shared package uart_pkg holds:
  - state encoding constants IDLE/START/DATA/PARITY/STOP, with the same encodings used by the receiver where the names overlap;
  - the data width constant (8);
  - a parity helper function shared with the receiver.
- Natural sub-module: baud_gen (counter producing a one-cycle bit_end strike, with a sync clear). It is reusable by the receiver with 16x oversampling.
- Datapath and FSM stay in tx_mod.

Test Plan:
1. Reset and idle: assert rst mid-idle, hold 3 cycles, release -> tx = 1, tx_rdy = 1, done = 0 throughout; no activity for 100 cycles.
2. Basic frame, CLKS_PER_BIT = 4, no parity, 1 stop, din = 8'hA5, wr for 1 cycle:
   - tx = 0 | 1,0,1,0,0,1,0,1 | 1, each held 4 cycles;
   - tx_rdy low for 40 cycles, then done pulses once.
3. Parity, PARITY_EN = 1:
   - even, din = 8'h07 -> parity bit 1;
   - odd, din = 8'h07 -> parity bit 0;
   - frame = 44 cycles at CLKS_PER_BIT = 4.
4. Back-to-back, wr held high, din = 8'h00 then 8'hFF, STOP_BITS = 2:
   - two frames of 44 cycles each, separated by exactly 1 idle-high cycle;
   - done pulses twice.
5. Ignored write: pulse wr with din = 8'h3C during the DATA state of an 8'hA5 frame -> frame bits unchanged; no second frame sent.
6. Reset mid-frame: assert rst during data bit 3 -> tx = 1 asynchronously, tx_rdy = 1; after release, a new 8'h5A frame is transmitted correctly from its start bit.
